// File: rtl/fib_checker.sv
// rtl/fib_checker.sv - Checks a streamed sequence of terms against the Fibonacci recurrence.
module fib_checker #(
    parameter int WIDTH   = 32,
    parameter int N_TERMS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [15:0]      err_count,
    output logic [15:0]      first_err_idx,
    output logic [15:0]      term_idx
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [15:0] LAST_IDX = 16'(N_TERMS - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] exp_a;
    logic [WIDTH-1:0] exp_b;
    logic             accept;
    logic             mismatch;

    // A start in the same cycle as a handshake wins; that term is dropped.
    assign accept   = in_valid && in_ready && !start;
    assign mismatch = (in_data != exp_a);
    assign busy     = (state == CHECK);
    assign done     = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            in_ready <= 1'b0;
        end else begin
            state    <= state_next;
            in_ready <= (state_next == CHECK);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CHECK;
            CHECK: begin
                if (start)
                    state_next = CHECK;
                else if (accept && (term_idx == LAST_IDX))
                    state_next = DONE;
            end
            DONE:    if (start) state_next = CHECK;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_a         <= '0;
            exp_b         <= WIDTH'(1);
            error         <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '0;
            term_idx      <= '0;
        end else if (start) begin
            exp_a         <= '0;
            exp_b         <= WIDTH'(1);
            error         <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '0;
            term_idx      <= '0;
        end else if (accept) begin
            exp_a    <= exp_b;
            exp_b    <= exp_a + exp_b;
            term_idx <= term_idx + 16'd1;
            if (mismatch) begin
                error <= 1'b1;
                if (err_count != 16'hFFFF)
                    err_count <= err_count + 16'd1;
                if (!error)
                    first_err_idx <= term_idx;
            end
        end
    end

endmodule

// File: tb/tb_fib_checker.sv
// tb/tb_fib_checker.sv - Scoreboard bench running 32-bit and 8-bit checkers on shared stimulus.
module tb_fib_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;

    logic        rdy32, bsy32, dn32, er32;
    logic [15:0] cnt32, fst32, idx32;
    logic        rdy8, bsy8, dn8, er8;
    logic [15:0] cnt8, fst8, idx8;

    always #5 clk = ~clk;

    fib_checker #(.WIDTH(32), .N_TERMS(16)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(rdy32), .busy(bsy32), .done(dn32),
        .error(er32), .err_count(cnt32), .first_err_idx(fst32), .term_idx(idx32)
    );

    fib_checker #(.WIDTH(8), .N_TERMS(16)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_data(in_data[7:0]), .in_ready(rdy8), .busy(bsy8), .done(dn8),
        .error(er8), .err_count(cnt8), .first_err_idx(fst8), .term_idx(idx8)
    );

    typedef struct {
        logic        rdy;
        logic        bsy;
        logic        dn;
        logic        er;
        logic [15:0] cnt;
        logic [15:0] first;
        logic [15:0] idx;
    } exp_t;

    exp_t        q32[$];
    exp_t        q8[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] fib[16];

    // reference model; st: 0 idle, 1 check, 2 done
    int          st = 0;
    logic [15:0] m_idx = '0;
    logic [31:0] a32 = '0, b32 = 32'd1;
    logic [7:0]  a8 = '0, b8 = 8'd1;
    logic        e32 = 1'b0, e8 = 1'b0;
    logic [15:0] c32 = '0, c8 = '0, f32 = '0, f8 = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cmp_out(input string p, input exp_t e, input logic rdy, input logic bsy,
                           input logic dn, input logic er, input logic [15:0] cnt,
                           input logic [15:0] fst, input logic [15:0] idx);
        chk({p, ".in_ready"},      32'(rdy), 32'(e.rdy));
        chk({p, ".busy"},          32'(bsy), 32'(e.bsy));
        chk({p, ".done"},          32'(dn),  32'(e.dn));
        chk({p, ".error"},         32'(er),  32'(e.er));
        chk({p, ".err_count"},     32'(cnt), 32'(e.cnt));
        chk({p, ".first_err_idx"}, 32'(fst), 32'(e.first));
        chk({p, ".term_idx"},      32'(idx), 32'(e.idx));
    endtask

    task automatic check_pending();
        exp_t e;
        while (q32.size() > 0) begin
            e = q32.pop_front();
            cmp_out("d32", e, rdy32, bsy32, dn32, er32, cnt32, fst32, idx32);
        end
        while (q8.size() > 0) begin
            e = q8.pop_front();
            cmp_out("d8", e, rdy8, bsy8, dn8, er8, cnt8, fst8, idx8);
        end
    endtask

    task automatic model_clear(input int new_st);
        st = new_st;
        m_idx = '0;
        a32 = '0; b32 = 32'd1; a8 = '0; b8 = 8'd1;
        e32 = 1'b0; e8 = 1'b0; c32 = '0; c8 = '0; f32 = '0; f8 = '0;
    endtask

    task automatic step(input logic s, input logic v, input logic [31:0] d);
        exp_t        e;
        logic [31:0] t32;
        logic [7:0]  t8;
        @(negedge clk);
        check_pending();
        start = s; in_valid = v; in_data = d;
        if (s) begin
            model_clear(1);
        end else if (st == 1 && v) begin
            if (d != a32) begin
                if (!e32) f32 = m_idx;
                e32 = 1'b1;
                if (c32 != 16'hFFFF) c32 = c32 + 16'd1;
            end
            if (d[7:0] != a8) begin
                if (!e8) f8 = m_idx;
                e8 = 1'b1;
                if (c8 != 16'hFFFF) c8 = c8 + 16'd1;
            end
            t32 = a32 + b32; a32 = b32; b32 = t32;
            t8 = a8 + b8; a8 = b8; b8 = t8;
            m_idx = m_idx + 16'd1;
            if (m_idx == 16'd16) st = 2;
        end
        e.rdy = (st == 1); e.bsy = (st == 1); e.dn = (st == 2);
        e.er = e32; e.cnt = c32; e.first = f32; e.idx = m_idx;
        q32.push_back(e);
        e.er = e8; e.cnt = c8; e.first = f8;
        q8.push_back(e);
    endtask

    task automatic run_terms(input int fault_idx, input logic [31:0] fault_val,
                             input bit gaps, input int stop_after);
        int   n = 0;
        logic v;
        while (st == 1 && int'(m_idx) < stop_after && n < 400) begin
            v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!v)
                step(0, 0, $urandom());
            else if (int'(m_idx) == fault_idx)
                step(0, 1, fault_val);
            else
                step(0, 1, fib[m_idx[3:0]]);
            n++;
        end
        if (n >= 400) chk("run_timeout", 32'(n), 32'd0);
    endtask

    task automatic idle_valid(input int k);
        for (int i = 0; i < k; i++) step(0, 1, $urandom());
        @(negedge clk);
        check_pending();
    endtask

    task automatic do_reset();
        @(negedge clk);
        check_pending();
        start = 1'b0; in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst.in_ready", 32'(rdy32), 0);
        chk("rst.busy",     32'(bsy32), 0);
        chk("rst.done",     32'(dn32),  0);
        chk("rst.error",    32'(er32),  0);
        chk("rst.err_count", 32'(cnt32), 0);
        chk("rst.first_err_idx", 32'(fst32), 0);
        chk("rst.term_idx", 32'(idx32), 0);
        chk("rst.d8_term_idx", 32'(idx8), 0);
        chk("rst.d8_in_ready", 32'(rdy8), 0);
        model_clear(0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        fib[0] = 32'd0; fib[1] = 32'd1;
        for (int i = 2; i < 16; i++) fib[i] = fib[i-1] + fib[i-2];

        do_reset();
        idle_valid(3);

        // clean run, in_valid held high
        step(1, 0, 0);
        run_terms(-1, 0, 0, 16);
        idle_valid(3);
        chk("clean.done", 32'(dn32), 1);
        chk("clean.error", 32'(er32), 0);
        chk("clean.err_count", 32'(cnt32), 0);
        chk("clean.term_idx", 32'(idx32), 16);

        // fault at index 5
        step(1, 0, 0);
        run_terms(5, 32'd7, 0, 16);
        idle_valid(1);
        chk("fault.error", 32'(er32), 1);
        chk("fault.err_count", 32'(cnt32), 1);
        chk("fault.first_err_idx", 32'(fst32), 5);
        chk("fault.d8_first_err_idx", 32'(fst8), 5);

        // throttled run; the 8-bit instance sees wrapped terms
        chk("wrap.fib14_mod256", 32'(fib[14][7:0]), 32'd121);
        chk("wrap.fib15_mod256", 32'(fib[15][7:0]), 32'd98);
        step(1, 0, 0);
        run_terms(-1, 0, 1, 16);
        idle_valid(4);
        chk("wrap.d8_error", 32'(er8), 0);
        chk("wrap.d8_done", 32'(dn8), 1);
        chk("wrap.d8_term_idx", 32'(idx8), 16);

        // restart after 4 terms; the term offered with start is dropped
        step(1, 0, 0);
        run_terms(-1, 0, 0, 4);
        step(1, 1, 32'hDEAD_BEEF);
        run_terms(-1, 0, 1, 16);
        idle_valid(1);
        chk("restart.term_idx", 32'(idx32), 16);
        chk("restart.error", 32'(er32), 0);

        // reset mid-run, then a full run
        step(1, 0, 0);
        run_terms(-1, 0, 0, 3);
        do_reset();
        idle_valid(2);
        step(1, 0, 0);
        run_terms(3, 32'd9, 1, 16);
        idle_valid(1);
        chk("post_rst.first_err_idx", 32'(fst32), 3);
        step(1, 0, 0);
        run_terms(-1, 0, 1, 16);
        idle_valid(1);
        chk("post_rst.error", 32'(er32), 0);
        chk("post_rst.done", 32'(dn32), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
